// File: rtl/alu_pkg.sv
// Shared types and operation codes for the sequential ALU and its multiplier.
package alu_pkg;

  typedef enum logic [1:0] {
    REPOSO = 2'd0,
    MULT   = 2'd1,
    FIN    = 2'd2
  } estado_t;

  localparam logic [1:0] OP_SUMA  = 2'b00;
  localparam logic [1:0] OP_RESTA = 2'b01;
  localparam logic [1:0] OP_COMP  = 2'b10;
  localparam logic [1:0] OP_MULT  = 2'b11;

endpackage

// File: rtl/alu_secuencial_multiplicador.sv
// Iterative shift-add unsigned multiplier: one partial product per clock, N clocks per product.
module multiplicador_secuencial #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cargar,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] producto,
  output logic           hecho
);

  localparam int CNT_W = $clog2(N) + 1;

  logic [2*N-1:0] acc_q, acc_d;
  logic [2*N-1:0] a_desp_q, a_desp_d;
  logic [N-1:0]   mult_q, mult_d;
  logic [CNT_W-1:0] cuenta_q, cuenta_d;
  logic           activo_q, activo_d;
  logic [2*N-1:0] suma_parcial;
  logic           ultima;

  // Accumulator plus the current partial product; on the last iteration this is the full product.
  assign suma_parcial = acc_q + (mult_q[0] ? a_desp_q : '0);
  assign ultima       = activo_q && (cuenta_q == CNT_W'(N - 1));
  assign producto     = suma_parcial;
  assign hecho        = ultima;

  // Load operands on cargar, otherwise run one shift-add iteration per cycle while active.
  always_comb begin
    acc_d    = acc_q;
    a_desp_d = a_desp_q;
    mult_d   = mult_q;
    cuenta_d = cuenta_q;
    activo_d = activo_q;
    if (cargar) begin
      acc_d    = '0;
      a_desp_d = {{N{1'b0}}, a};
      mult_d   = b;
      cuenta_d = '0;
      activo_d = 1'b1;
    end else if (activo_q) begin
      acc_d    = suma_parcial;
      a_desp_d = a_desp_q << 1;
      mult_d   = mult_q >> 1;
      cuenta_d = cuenta_q + CNT_W'(1);
      if (ultima) begin
        activo_d = 1'b0;
      end
    end
  end

  // Iteration state registers, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      a_desp_q <= '0;
      mult_q   <= '0;
      cuenta_q <= '0;
      activo_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      a_desp_q <= a_desp_d;
      mult_q   <= mult_d;
      cuenta_q <= cuenta_d;
      activo_q <= activo_d;
    end
  end

endmodule

// File: rtl/alu_secuencial.sv
// Registered ALU: add/subtract/compare in one cycle, multiply via the iterative multiplier.
module alu_secuencial
  import alu_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           inicio,
  input  logic [1:0]     sel,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           ocupado,
  output logic           valido,
  output logic [2*N-1:0] s,
  output logic           sal,
  output logic           pout,
  output logic           eout,
  output logic           mout
);

  estado_t state_q, state_d;

  logic [2*N-1:0] s_q, s_d;
  logic           sal_q, sal_d;
  logic           pout_q, pout_d;
  logic           eout_q, eout_d;
  logic           mout_q, mout_d;

  logic           aceptar;
  logic           cargar;
  logic [2*N-1:0] producto;
  logic           hecho;
  logic [N:0]     suma_ext;
  logic [N:0]     resta_ext;

  // An operation is only taken while idle; the multiplier is loaded on a multiply accept.
  assign aceptar   = (state_q == REPOSO) && inicio;
  assign cargar    = aceptar && (sel == OP_MULT);
  assign suma_ext  = {1'b0, a} + {1'b0, b};
  assign resta_ext = {1'b0, a} - {1'b0, b};

  multiplicador_secuencial #(.N(N)) u_mult (
    .clk      (clk),
    .rst      (rst),
    .cargar   (cargar),
    .a        (a),
    .b        (b),
    .producto (producto),
    .hecho    (hecho)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= REPOSO;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: simple ops go straight to FIN, multiply waits for the last iteration.
  always_comb begin
    state_d = state_q;
    case (state_q)
      REPOSO: begin
        if (inicio) begin
          state_d = (sel == OP_MULT) ? MULT : FIN;
        end
      end
      MULT: begin
        if (hecho) begin
          state_d = FIN;
        end
      end
      FIN:     state_d = REPOSO;
      default: state_d = REPOSO;
    endcase
  end

  // Status outputs decoded from the state register.
  always_comb begin
    ocupado = (state_q != REPOSO);
    valido  = (state_q == FIN);
  end

  // Result fields: cleared on every accept, then filled by the op that produces them.
  always_comb begin
    s_d    = s_q;
    sal_d  = sal_q;
    pout_d = pout_q;
    eout_d = eout_q;
    mout_d = mout_q;
    if (aceptar) begin
      s_d    = '0;
      sal_d  = 1'b0;
      pout_d = 1'b0;
      eout_d = 1'b0;
      mout_d = 1'b0;
      case (sel)
        OP_SUMA: begin
          s_d[N-1:0] = suma_ext[N-1:0];
          sal_d      = suma_ext[N];
        end
        OP_RESTA: begin
          s_d[N-1:0] = resta_ext[N-1:0];
          sal_d      = resta_ext[N];
        end
        OP_COMP: begin
          pout_d = (a > b);
          eout_d = (a == b);
          mout_d = (a < b);
        end
        default: ;
      endcase
    end else if ((state_q == MULT) && hecho) begin
      s_d = producto;
    end
  end

  // Output registers, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q    <= '0;
      sal_q  <= 1'b0;
      pout_q <= 1'b0;
      eout_q <= 1'b0;
      mout_q <= 1'b0;
    end else begin
      s_q    <= s_d;
      sal_q  <= sal_d;
      pout_q <= pout_d;
      eout_q <= eout_d;
      mout_q <= mout_d;
    end
  end

  assign s    = s_q;
  assign sal  = sal_q;
  assign pout = pout_q;
  assign eout = eout_q;
  assign mout = mout_q;

endmodule

// File: tb/tb_alu_secuencial.sv
// Directed-vector bench for alu_secuencial with N=8.
module tb_alu_secuencial;

  localparam int N = 8;

  logic           clk;
  logic           rst;
  logic           inicio;
  logic [1:0]     sel;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           ocupado;
  logic           valido;
  logic [2*N-1:0] s;
  logic           sal;
  logic           pout;
  logic           eout;
  logic           mout;

  int pass_cnt;
  int total_cnt;

  // Observed bundle: {s, sal, pout, eout, mout, ocupado, valido}
  logic [2*N+5:0] obs;
  assign obs = {s, sal, pout, eout, mout, ocupado, valido};

  alu_secuencial #(.N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .inicio  (inicio),
    .sel     (sel),
    .a       (a),
    .b       (b),
    .ocupado (ocupado),
    .valido  (valido),
    .s       (s),
    .sal     (sal),
    .pout    (pout),
    .eout    (eout),
    .mout    (mout)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an operation with inicio high across one edge, then drop inicio.
  task automatic accept(input logic [1:0] op, input logic [N-1:0] va, input logic [N-1:0] vb);
    sel    = op;
    a      = va;
    b      = vb;
    inicio = 1'b1;
    tick();
    inicio = 1'b0;
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    inicio = 1'b1;
    sel    = 2'b00;
    a      = 8'd1;
    b      = 8'd1;
    for (int i = 0; i < 2; i++) begin
      tick();
      total_cnt++;
      if (obs !== 22'h0) $display("[TB] FAIL reset_cycle%0d obs=%h expected=%h", i, obs, 22'h0);
      else pass_cnt++;
    end
    rst    = 1'b0;
    inicio = 1'b0;
    tick();
    total_cnt++;
    if (obs !== 22'h0) $display("[TB] FAIL reset_no_accept obs=%h expected=%h", obs, 22'h0);
    else pass_cnt++;
  endtask

  task automatic test_suma_resta();
    logic [2*N+5:0] exp_v;
    accept(2'b00, 8'd200, 8'd100);
    exp_v = {16'h002C, 1'b1, 3'b000, 2'b11};
    total_cnt++;
    if (obs !== exp_v) $display("[TB] FAIL suma_valido obs=%h expected=%h", obs, exp_v);
    else pass_cnt++;
    tick();
    exp_v = {16'h002C, 1'b1, 3'b000, 2'b00};
    total_cnt++;
    if (obs !== exp_v) $display("[TB] FAIL suma_hold obs=%h expected=%h", obs, exp_v);
    else pass_cnt++;

    accept(2'b01, 8'd5, 8'd9);
    exp_v = {16'h00FC, 1'b1, 3'b000, 2'b11};
    total_cnt++;
    if (obs !== exp_v) $display("[TB] FAIL resta_borrow obs=%h expected=%h", obs, exp_v);
    else pass_cnt++;
    tick();

    accept(2'b01, 8'd9, 8'd5);
    exp_v = {16'h0004, 1'b0, 3'b000, 2'b11};
    total_cnt++;
    if (obs !== exp_v) $display("[TB] FAIL resta_noborrow obs=%h expected=%h", obs, exp_v);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_comp();
    logic [2*N+5:0] exp_v;
    accept(2'b10, 8'd7, 8'd7);
    exp_v = {16'h0000, 1'b0, 3'b010, 2'b11};
    total_cnt++;
    if (obs !== exp_v) $display("[TB] FAIL comp_equal obs=%h expected=%h", obs, exp_v);
    else pass_cnt++;
    tick();

    accept(2'b10, 8'd8, 8'd3);
    exp_v = {16'h0000, 1'b0, 3'b100, 2'b11};
    total_cnt++;
    if (obs !== exp_v) $display("[TB] FAIL comp_greater obs=%h expected=%h", obs, exp_v);
    else pass_cnt++;
    tick();

    accept(2'b10, 8'd3, 8'd8);
    exp_v = {16'h0000, 1'b0, 3'b001, 2'b11};
    total_cnt++;
    if (obs !== exp_v) $display("[TB] FAIL comp_less obs=%h expected=%h", obs, exp_v);
    else pass_cnt++;
    tick();
  endtask

  // Multiply with fixed latency; optionally pulse inicio with new operands mid-run.
  task automatic test_mult(input logic [N-1:0] va, input logic [N-1:0] vb,
                           input logic [2*N-1:0] prod, input bit disturb);
    logic [2*N+5:0] exp_v;
    accept(2'b11, va, vb);
    for (int i = 0; i < N; i++) begin
      total_cnt++;
      if ({ocupado, valido} !== 2'b10)
        $display("[TB] FAIL mult_busy_e%0d ocupado_valido=%b expected=%b", i, {ocupado, valido}, 2'b10);
      else pass_cnt++;
      if (disturb && (i == 2 || i == 5)) begin
        inicio = 1'b1;
        sel    = 2'b00;
        a      = 8'd3;
        b      = 8'd3;
      end else begin
        inicio = 1'b0;
      end
      tick();
    end
    inicio = 1'b0;
    exp_v = {prod, 1'b0, 3'b000, 2'b11};
    total_cnt++;
    if (obs !== exp_v) $display("[TB] FAIL mult_result obs=%h expected=%h", obs, exp_v);
    else pass_cnt++;
    tick();
    exp_v = {prod, 1'b0, 3'b000, 2'b00};
    total_cnt++;
    if (obs !== exp_v) $display("[TB] FAIL mult_idle obs=%h expected=%h", obs, exp_v);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_mult();
    logic [2*N+5:0] exp_v;
    accept(2'b11, 8'd255, 8'd255);
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total_cnt++;
    if (obs !== 22'h0) $display("[TB] FAIL mid_reset obs=%h expected=%h", obs, 22'h0);
    else pass_cnt++;
    accept(2'b00, 8'd10, 8'd20);
    exp_v = {16'h001E, 1'b0, 3'b000, 2'b11};
    total_cnt++;
    if (obs !== exp_v) $display("[TB] FAIL after_reset_suma obs=%h expected=%h", obs, exp_v);
    else pass_cnt++;
    tick();
    exp_v = {16'h001E, 1'b0, 3'b000, 2'b00};
    total_cnt++;
    if (obs !== exp_v) $display("[TB] FAIL after_reset_hold obs=%h expected=%h", obs, exp_v);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [2*N+5:0] exp_v;
    inicio = 1'b1;
    sel    = 2'b11;
    a      = 8'd3;
    b      = 8'd5;
    tick();
    sel = 2'b10;
    a   = 8'd4;
    b   = 8'd9;
    for (int i = 0; i < N; i++) tick();
    exp_v = {16'h000F, 1'b0, 3'b000, 2'b11};
    total_cnt++;
    if (obs !== exp_v) $display("[TB] FAIL b2b_mult obs=%h expected=%h", obs, exp_v);
    else pass_cnt++;
    tick();
    exp_v = {16'h000F, 1'b0, 3'b000, 2'b00};
    total_cnt++;
    if (obs !== exp_v) $display("[TB] FAIL b2b_mult_idle obs=%h expected=%h", obs, exp_v);
    else pass_cnt++;
    tick();
    exp_v = {16'h0000, 1'b0, 3'b001, 2'b11};
    total_cnt++;
    if (obs !== exp_v) $display("[TB] FAIL b2b_comp_clears obs=%h expected=%h", obs, exp_v);
    else pass_cnt++;
    sel = 2'b00;
    a   = 8'd1;
    b   = 8'd2;
    tick();
    exp_v = {16'h0000, 1'b0, 3'b001, 2'b00};
    total_cnt++;
    if (obs !== exp_v) $display("[TB] FAIL b2b_comp_idle obs=%h expected=%h", obs, exp_v);
    else pass_cnt++;
    tick();
    exp_v = {16'h0003, 1'b0, 3'b000, 2'b11};
    total_cnt++;
    if (obs !== exp_v) $display("[TB] FAIL b2b_suma obs=%h expected=%h", obs, exp_v);
    else pass_cnt++;
    sel = 2'b01;
    a   = 8'd2;
    b   = 8'd1;
    tick();
    tick();
    exp_v = {16'h0001, 1'b0, 3'b000, 2'b11};
    total_cnt++;
    if (obs !== exp_v) $display("[TB] FAIL b2b_resta obs=%h expected=%h", obs, exp_v);
    else pass_cnt++;
    inicio = 1'b0;
    tick();
    tick();
    exp_v = {16'h0001, 1'b0, 3'b000, 2'b00};
    total_cnt++;
    if (obs !== exp_v) $display("[TB] FAIL b2b_final_idle obs=%h expected=%h", obs, exp_v);
    else pass_cnt++;
  endtask

  // Scenario sequence followed by the summary line.
  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst       = 1'b1;
    inicio    = 1'b0;
    sel       = 2'b00;
    a         = '0;
    b         = '0;
    test_reset();
    test_suma_resta();
    test_comp();
    test_mult(8'd255, 8'd255, 16'hFE01, 1'b1);
    test_mult(8'd0, 8'd255, 16'h0000, 1'b0);
    test_mult(8'd1, 8'd128, 16'h0080, 1'b0);
    test_reset_mid_mult();
    test_back_to_back();
    $display("[TB] %0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
